// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART: data register at BASE_ADDR, status at BASE_ADDR+1, with
// buffered RX/TX FIFOs so the core only stalls on empty-read or full-write.
module uart_mmio_fifo #(
  parameter int          CLK_PER_BIT = 868,
  parameter int          RX_DEPTH    = 16,
  parameter int          TX_DEPTH    = 16,
  parameter int          ADDR_W      = 25,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              n_stall,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mre,
  input  logic              mwe,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              io_hit,
  output logic              io_stall,
  input  logic              rxd,
  output logic              txd
);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int CW    = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLK_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLK_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  logic hit_data, hit_stat, rx_pop, stat_rd, tx_push, tx_pop;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_done, rx_push, ovr_evt, ferr_evt;
  logic ovr_d, ovr_q, ferr_d, ferr_q;
  logic unused_wdata;

  assign hit_data = (addr == ADDR_W'(BASE_ADDR));
  assign hit_stat = (addr == ADDR_W'(BASE_ADDR + 1));
  assign io_hit   = (hit_data | hit_stat) & (mre | mwe);
  assign io_stall = hit_data & ((mre & rx_empty) | (mwe & tx_full));
  assign rx_pop   = n_stall & mre & hit_data & ~rx_empty;
  assign stat_rd  = n_stall & mre & hit_stat;
  assign tx_push  = n_stall & mwe & hit_data & ~tx_full;
  assign unused_wdata = ^wdata[31:8];

  // ---------------- RX FIFO ----------------
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wp_q, rx_rp_q;
  logic [RX_AW:0]   rx_cnt_q;
  logic [7:0]       rx_sh_q;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == (RX_AW+1)'(RX_DEPTH));
  assign rx_push  = rx_done & (~rx_full | rx_pop);
  assign ovr_evt  = rx_done & rx_full & ~rx_pop;

  always_ff @(posedge clk) if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
      if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
      rx_cnt_q <= rx_cnt_q + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
    end
  end

  // ---------------- TX FIFO ----------------
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wp_q, tx_rp_q;
  logic [TX_AW:0]   tx_cnt_q;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == (TX_AW+1)'(TX_DEPTH));

  always_ff @(posedge clk) if (tx_push) tx_mem[tx_wp_q] <= wdata[7:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
      if (tx_pop)  tx_rp_q <= tx_rp_q + 1'b1;
      tx_cnt_q <= tx_cnt_q + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);
    end
  end

  // ---------------- RX FSM ----------------
  state_e        rx_st_q;
  logic [CW-1:0] rx_bd_q;
  logic [2:0]    rx_bit_q;
  logic          rx_brk_q, rx_s1_q, rx_s2_q, rx_s3_q, rx_stop_smp;

  assign rx_stop_smp = (rx_st_q == S_STOP) & ~rx_brk_q & (rx_bd_q == BIT_END);
  assign rx_done     = rx_stop_smp & rx_s2_q;
  assign ferr_evt    = rx_stop_smp & ~rx_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q <= 1'b1; rx_s2_q <= 1'b1; rx_s3_q <= 1'b1;
      rx_st_q <= S_IDLE; rx_bd_q <= '0; rx_bit_q <= '0;
      rx_sh_q <= '0; rx_brk_q <= 1'b0;
    end else begin
      rx_s1_q <= rxd; rx_s2_q <= rx_s1_q; rx_s3_q <= rx_s2_q;
      case (rx_st_q)
        S_IDLE: if (rx_s3_q & ~rx_s2_q) begin
          rx_st_q <= S_START; rx_bd_q <= '0;
        end
        S_START: if (rx_bd_q == HALF_END) begin
          rx_bd_q  <= '0;
          rx_bit_q <= '0;
          rx_st_q  <= rx_s2_q ? S_IDLE : S_DATA;
        end else rx_bd_q <= rx_bd_q + 1'b1;
        S_DATA: if (rx_bd_q == BIT_END) begin
          rx_bd_q  <= '0;
          rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
          rx_bit_q <= rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
        end else rx_bd_q <= rx_bd_q + 1'b1;
        default: begin
          // After a framing error, hold off until the line idles high again.
          if (rx_brk_q) begin
            if (rx_s2_q) begin rx_brk_q <= 1'b0; rx_st_q <= S_IDLE; end
          end else if (rx_bd_q == BIT_END) begin
            rx_bd_q <= '0;
            if (rx_s2_q) rx_st_q <= S_IDLE;
            else rx_brk_q <= 1'b1;
          end else rx_bd_q <= rx_bd_q + 1'b1;
        end
      endcase
    end
  end

  // ---------------- TX FSM ----------------
  state_e        tx_st_q;
  logic [CW-1:0] tx_bd_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_sh_q;
  logic          txd_q;

  // Reloading straight from STOP keeps back-to-back frames gapless.
  assign tx_pop = ~tx_empty & ((tx_st_q == S_IDLE) |
                               ((tx_st_q == S_STOP) & (tx_bd_q == BIT_END)));
  assign txd    = txd_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st_q <= S_IDLE; tx_bd_q <= '0; tx_bit_q <= '0;
      tx_sh_q <= '0; txd_q <= 1'b1;
    end else begin
      case (tx_st_q)
        S_IDLE: if (tx_pop) begin
          tx_sh_q <= tx_mem[tx_rp_q]; txd_q <= 1'b0;
          tx_st_q <= S_START; tx_bd_q <= '0;
        end
        S_START: if (tx_bd_q == BIT_END) begin
          tx_bd_q <= '0; tx_bit_q <= '0;
          txd_q   <= tx_sh_q[0]; tx_st_q <= S_DATA;
        end else tx_bd_q <= tx_bd_q + 1'b1;
        S_DATA: if (tx_bd_q == BIT_END) begin
          tx_bd_q <= '0;
          if (tx_bit_q == 3'd7) begin
            txd_q <= 1'b1; tx_st_q <= S_STOP;
          end else begin
            txd_q    <= tx_sh_q[1];
            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
            tx_bit_q <= tx_bit_q + 1'b1;
          end
        end else tx_bd_q <= tx_bd_q + 1'b1;
        default: if (tx_bd_q == BIT_END) begin
          tx_bd_q <= '0;
          if (tx_pop) begin
            tx_sh_q <= tx_mem[tx_rp_q]; txd_q <= 1'b0; tx_st_q <= S_START;
          end else tx_st_q <= S_IDLE;
        end else tx_bd_q <= tx_bd_q + 1'b1;
      endcase
    end
  end

  // ---------------- Registers / read data ----------------
  // A new error event in the same cycle as a status read keeps the flag set.
  assign ovr_d  = ovr_evt  | (ovr_q  & ~stat_rd);
  assign ferr_d = ferr_evt | (ferr_q & ~stat_rd);

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0; ovr_q <= 1'b0; ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_d;
      ferr_q <= ferr_d;
      if (rx_pop)
        rdata <= {24'b0, rx_mem[rx_rp_q]};
      else if (stat_rd)
        rdata <= {16'b0, 8'(rx_cnt_q), 4'b0, ferr_q, ovr_q, ~tx_full, ~rx_empty};
    end
  end
endmodule
